// File: rtl/dmadd_seq.sv
// dmadd_seq: job-stream initiator for the delta-MADD engine (reset, init, load, run, capture, respond).
// Results held until res_ready; optional job_count port enabled by DMADD_SEQ_JOBCNT_EN.
module dmadd_seq #(
  parameter int RUN_CYCLES = 18,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_mode,
  input  logic [3:0]  cmd_index,
  input  logic [3:0]  cmd_data,
  input  logic        cmd_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [11:0] res_value,
  output logic        res_err,
  output logic        eng_rst_n,
  output logic [3:0]  eng_index,
  output logic [3:0]  eng_data,
  output logic [1:0]  eng_insn,
  output logic        eng_load,
  output logic        eng_run,
  input  logic [7:0]  eng_out,
  input  logic [3:0]  eng_out_top
`ifdef DMADD_SEQ_JOBCNT_EN
  ,
  output logic [7:0]  job_count
`endif
);

  typedef enum logic [2:0] {IDLE, ERST, INIT, LOAD, RUN, CAPT, RESP} state_t;

  localparam logic [1:0] M_MIN  = 2'b00;
  localparam logic [1:0] M_MADD = 2'b10;
  localparam logic [1:0] M_ILL  = 2'b11;
  localparam logic [1:0] I_NOP  = 2'b11;

  state_t      state;
  logic [1:0]  mode;
  logic        drop;
  logic [3:0]  skid_index;
  logic [3:0]  skid_data;
  logic        skid_last;
  logic        done;
  logic [15:0] cnt;
  logic [1:0]  load_insn;
  logic        cmd_hs;

  assign load_insn = (mode == M_MADD) ? 2'b10 : 2'b00;
  assign cmd_hs    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode       <= M_MIN;
      drop       <= 1'b0;
      skid_index <= '0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      cmd_ready  <= 1'b0;
      res_valid  <= 1'b0;
      res_value  <= '0;
      res_err    <= 1'b0;
      eng_rst_n  <= 1'b0;
      eng_insn   <= I_NOP;
      eng_load   <= 1'b0;
      eng_run    <= 1'b0;
      eng_index  <= '0;
      eng_data   <= '0;
`ifdef DMADD_SEQ_JOBCNT_EN
      job_count  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          eng_rst_n <= 1'b1;
          eng_insn  <= I_NOP;
          eng_load  <= 1'b0;
          eng_run   <= 1'b0;
          cmd_ready <= 1'b1;
          if (cmd_hs) begin
            if (drop || cmd_mode == M_ILL) begin
              // Illegal job: swallow beats up to cmd_last without touching the engine.
              if (cmd_last) begin
                drop      <= 1'b0;
                cmd_ready <= 1'b0;
                res_valid <= 1'b1;
                res_err   <= 1'b1;
                res_value <= '0;
                state     <= RESP;
              end else begin
                drop <= 1'b1;
              end
            end else begin
              mode       <= cmd_mode;
              skid_index <= cmd_index;
              skid_data  <= cmd_data;
              skid_last  <= cmd_last;
              cmd_ready  <= 1'b0;
              eng_rst_n  <= 1'b0;
              cnt        <= 16'(RST_CYCLES - 1);
              state      <= ERST;
            end
          end
        end
        ERST: begin
          if (cnt == '0) begin
            eng_rst_n <= 1'b1;
            eng_insn  <= (mode == M_MIN) ? 2'b00 : 2'b01;
            state     <= INIT;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        INIT: begin
          eng_load  <= 1'b1;
          eng_insn  <= load_insn;
          eng_index <= skid_index;
          eng_data  <= skid_data;
          done      <= skid_last;
          cmd_ready <= !skid_last;
          state     <= LOAD;
        end
        LOAD: begin
          if (done) begin
            done      <= 1'b0;
            eng_load  <= 1'b0;
            eng_run   <= 1'b1;
            eng_insn  <= mode;
            cmd_ready <= 1'b0;
            cnt       <= 16'(RUN_CYCLES - 1);
            state     <= RUN;
          end else if (cmd_hs) begin
            eng_load  <= 1'b1;
            eng_insn  <= load_insn;
            eng_index <= cmd_index;
            eng_data  <= cmd_data;
            done      <= cmd_last;
            cmd_ready <= !cmd_last;
          end else begin
            eng_load  <= 1'b0;
            eng_insn  <= I_NOP;
            cmd_ready <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            eng_run  <= 1'b0;
            eng_insn <= I_NOP;
            state    <= CAPT;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        CAPT: begin
          res_value <= {eng_out_top, eng_out};
          res_err   <= 1'b0;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
`ifdef DMADD_SEQ_JOBCNT_EN
            job_count <= job_count + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmadd_seq.md
Name: dmadd_seq

Overview:
- Host-side initiator for the delta-MADD engine (16 x 10-bit cell array; MIN/MAX search and MADD double-accumulate).
- Accepts a job as a valid/ready stream of (index, data) beats plus a mode, then drives the engine pins through soft-reset, initialise, load and run phases.
- Captures the engine's 12-bit result and returns it on a valid/ready result port. Sits between the host bus adapter and the engine.

Parameters:
- RUN_CYCLES, 18, run-phase length in clocks; must be >= 17 (engine needs 16 run clocks plus 1 output-register clock).
- RST_CYCLES, 2, clocks eng_rst_n is held low at job start; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  job beat valid
- cmd_ready  out  1  job beat accepted when cmd_valid & cmd_ready
- cmd_mode  in  2  00 MIN, 01 MAX, 10 MADD, 11 illegal; sampled on first beat of job only
- cmd_index  in  4  cell index
- cmd_data  in  4  unsigned addend (ignored for MIN/MAX)
- cmd_last  in  1  final beat of job
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready
- res_value  out  12  captured {eng_out_top, eng_out}
- res_err  out  1  job had illegal mode
- eng_rst_n  out  1  engine reset
- eng_index  out  4  engine index
- eng_data  out  4  engine data
- eng_insn  out  2  engine insn
- eng_load  out  1  engine load
- eng_run  out  1  engine run
- eng_out  in  8  engine result low
- eng_out_top  in  4  engine result high

Behaviour:
- All engine-side and result outputs are registered.
- Reset values:
  - state IDLE; cmd_ready 0; res_valid 0; res_value 0; res_err 0.
  - eng_rst_n 0; eng_insn 11; eng_load 0; eng_run 0; eng_index 0; eng_data 0.
- States: IDLE, ERST, INIT, LOAD, RUN, CAPT, RESP.
- IDLE:
  - eng_rst_n 1, eng_insn 11 (engine no-op), cmd_ready 1.
  - On handshake: latch mode. mode 11: drop beats through cmd_last (cmd_ready held 1), then RESP with res_err 1, res_value 0. Otherwise the first beat is held in a 1-entry skid register and the FSM goes to ERST.
- ERST: eng_rst_n 0 for RST_CYCLES clocks; cmd_ready 0.
- INIT: eng_rst_n 1, load 0, run 0, for one clock. eng_insn 00 for MIN, 01 for MADD or MAX (MADD runs downward).
- LOAD:
  - First issue the skid beat, then one beat per accepted handshake.
  - Each issued beat: eng_load 1, eng_insn 00 (MIN/MAX) or 10 (MADD), eng_index/eng_data from the beat, for exactly one clock.
  - Clocks without a beat: eng_load 0, eng_insn 11.
  - cmd_ready 1 in LOAD except the clock the skid beat is issued.
  - Beat with cmd_last: issue it, then go to RUN. A job with a single beat is legal.
- RUN: eng_run 1, eng_load 0, eng_insn = mode, for RUN_CYCLES clocks (counter).
- CAPT: eng_run 0, eng_insn 11; res_value <= {eng_out_top, eng_out}; go to RESP.
- RESP:
  - res_valid 1; res_value/res_err stable until res_ready.
  - On handshake: res_valid 0, clear res_err, go to IDLE.
  - cmd_ready 0 throughout ERST, INIT, RUN, CAPT, RESP.
- Repeated indices within a job are passed through unchanged (MADD accumulates). Index 0 in MADD is passed through (engine wraps index-1 to 15).
- Asynchronous reset mid-job: immediate return to reset values; job lost; eng_rst_n asserted low so the engine clears too.
- res_ready asserted outside RESP is ignored.

Optional Feature:
- Macro DMADD_SEQ_JOBCNT_EN.
- Defined: adds output job_count [7:0], reset 0, incremented on each result handshake including error results; wraps 255 -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- MIN job, beats (5,0),(9,last) -> eng_load pulses index 5 then 9, 18 run clocks, res_value 0x005, res_err 0.
- MAX job, same beats -> res_value 0x009.
- MADD job, single beat (3,2,last) -> INIT insn 01, load insn 10, res_value 0x006.
- Illegal mode 11, three beats -> all accepted, no eng_load pulses, eng_rst_n stays 1; res_err 1, res_value 0.
- res_ready held low 10 clocks in RESP -> res_valid/res_value stable; cmd_ready 0 until handshake, then 1 in IDLE.
- rst_n asserted during RUN -> all outputs at reset values the same clock; next MIN job (7,last) returns 0x007.
